stream_packet_arbiter: RTL

//   Packet-granular round-robin arbiter that shares one AXI-Stream byte channel among NUM_INPUTS sources.

---
 rtl/stream_packet_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_packet_arbiter
// Purpose  : Packet-granular round-robin arbiter that shares one AXI-Stream
//            byte channel among NUM_INPUTS sources. A grant is held from the
//            first beat of a packet until that source's tlast beat, so
//            packets never interleave. m_tid carries the granted source
//            index so a downstream labeler can tag each packet.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk         in   clock, rising edge
//   areset       in   asynchronous reset, active-high
//   s_tvalid     in   per-source valid                    [NUM_INPUTS]
//   s_tready     out  per-source ready                    [NUM_INPUTS]
//   s_tdata      in   source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tlast      in   per-source end of packet            [NUM_INPUTS]
//   enable_mask  in   1 = source may be granted           [NUM_INPUTS]
//   m_tvalid     out  output valid (registered)
//   m_tready     in   output ready
//   m_tdata      out  output data (registered)            [DATA_WIDTH]
//   m_tlast      out  output end of packet (registered)
//   m_tid        out  granted index, zero-extended        [DATA_WIDTH]
//   busy         out  high while a grant is locked
// ============================================================================
module stream_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_INPUTS-1:0]            s_tvalid,
    output logic [NUM_INPUTS-1:0]            s_tready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_INPUTS-1:0]            s_tlast,
    input  logic [NUM_INPUTS-1:0]            enable_mask,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tlast,
    output logic [DATA_WIDTH-1:0]            m_tid,
    output logic                             busy
);

    localparam int c_IDX_W = $clog2(NUM_INPUTS);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // Reset value of the last grant: the highest index, so source 0 is
    // the first candidate after reset.
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_INPUTS - 1);

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting index after 'last', wrapping.
    // ------------------------------------------------------------------
    function automatic logic [c_IDX_W-1:0] f_rr_pick(
        input logic [NUM_INPUTS-1:0] req,
        input logic [c_IDX_W-1:0]    last
    );
        logic [c_IDX_W-1:0] pick;
        logic [c_IDX_W-1:0] idx_n;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx   = (int'(last) + k) % NUM_INPUTS;
            idx_n = c_IDX_W'(idx);
            if (!found && req[idx_n]) begin
                pick  = idx_n;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_grant;
    logic [c_IDX_W-1:0]    r_last_grant;
    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tid;

    logic [NUM_INPUTS-1:0] w_req;
    logic                  w_any_req;
    logic [c_IDX_W-1:0]    w_pick;
    logic                  w_out_free;
    logic                  w_ready_en;
    logic                  w_busy;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_src_data [NUM_INPUTS];

    assign w_req     = s_tvalid & enable_mask;
    assign w_any_req = |w_req;
    assign w_pick    = f_rr_pick(w_req, r_last_grant);

    // Output register can take a new beat when empty or draining this cycle.
    assign w_out_free = !r_m_tvalid || m_tready;

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_src
            assign w_src_data[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign s_tready[i]   = w_ready_en && (r_grant == c_IDX_W'(i));
        end
    endgenerate

    assign w_sel_data = w_src_data[r_grant];
    assign w_sel_last = s_tlast[r_grant];
    assign w_accept   = |(s_tvalid & s_tready);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy     = 1'b0;
        w_ready_en = 1'b0;
        case (r_state)
            c_ST_LOCKED: begin
                w_busy     = 1'b1;
                w_ready_en = w_out_free;
            end
            default: begin
                w_busy     = 1'b0;
                w_ready_en = 1'b0;
            end
        endcase
    end

    assign busy = w_busy;

    // ------------------------------------------------------------------
    // Grant bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_grant      <= '0;
            r_last_grant <= c_LAST_IDX;
        end else begin
            if ((r_state == c_ST_IDLE) && w_any_req) begin
                r_grant <= w_pick;
            end
            if (w_accept && w_sel_last) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage. Holds its contents while stalled; a beat left
    // pending at packet end stays valid through IDLE until taken.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
        end else begin
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tlast  <= w_sel_last;
                r_m_tid    <= DATA_WIDTH'(r_grant);
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tlast  = r_m_tlast;
    assign m_tid    = r_m_tid;

endmodule
`default_nettype wire
